// File: rtl/ram_bist_seq_if.sv
// -----------------------------------------------------------------------------
// ram_bist_seq_if
// Single-port synchronous RAM bus (altsyncram style) between the BIST
// sequencer and the memory under test.
//   ram_addr : word address            (master -> slave)
//   ram_data : write data              (master -> slave)
//   ram_wren : write enable            (master -> slave)
//   ram_q    : read data, RD_LAT late  (slave  -> master)
// -----------------------------------------------------------------------------
interface ram_bist_seq_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  modport master (output ram_addr, output ram_data, output ram_wren, input ram_q);
  modport slave  (input ram_addr, input ram_data, input ram_wren, output ram_q);
endinterface

// File: rtl/ram_bist_seq.sv
// -----------------------------------------------------------------------------
// ram_bist_seq
// Write/read-back exerciser for a single-port synchronous RAM. Fills every
// word with a selectable pattern, reads the whole array back, compares each
// word and reports pass/fail, the mismatch count and the first bad address.
//
// Parameters: DW (data width 2..32), AW (address width, DEPTH = 2**AW),
//             RD_LAT (address-to-ram_q latency 1..4), HB_BIT (heartbeat bit).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (accepted only in IDLE)
//   mode, seed      pattern select / seed, latched at start
//   ram             RAM bus (ram_bist_seq_if.master)
//   busy, done      run in progress / one-cycle end-of-run pulse
//   pass, err_cnt   result of last run, saturating mismatch count
//   first_err_addr  address of the first mismatch (0 if none)
//   led             led[0] heartbeat, led[1] = ~pass
// Optional feature macro: RAM_BIST_LOOP_EN -- rerun back-to-back while start
// is held, accumulating errors across loops.
// -----------------------------------------------------------------------------
module ram_bist_seq #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 2,
  parameter int HB_BIT = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DW-1:0]         seed,
  ram_bist_seq_if.master        ram,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [AW-1:0]         first_err_addr,
  output logic [1:0]            led
);

  localparam int HBW = HB_BIT + 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;
  typedef enum logic [1:0] {PAT_ADD = 2'd0, PAT_WALK = 2'd1, PAT_LFSR = 2'd2, PAT_INV = 2'd3} pat_e;

  // Galois (right-shift) tap masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:  lfsr_taps = 32'h0000_0003;  3:  lfsr_taps = 32'h0000_0006;
      4:  lfsr_taps = 32'h0000_000C;  5:  lfsr_taps = 32'h0000_0014;
      6:  lfsr_taps = 32'h0000_0030;  7:  lfsr_taps = 32'h0000_0060;
      8:  lfsr_taps = 32'h0000_00B8;  9:  lfsr_taps = 32'h0000_0110;
      10: lfsr_taps = 32'h0000_0240;  11: lfsr_taps = 32'h0000_0500;
      12: lfsr_taps = 32'h0000_0829;  13: lfsr_taps = 32'h0000_100D;
      14: lfsr_taps = 32'h0000_2015;  15: lfsr_taps = 32'h0000_6000;
      16: lfsr_taps = 32'h0000_D008;  17: lfsr_taps = 32'h0001_2000;
      18: lfsr_taps = 32'h0002_0400;  19: lfsr_taps = 32'h0004_0023;
      20: lfsr_taps = 32'h0009_0000;  21: lfsr_taps = 32'h0014_0000;
      22: lfsr_taps = 32'h0030_0000;  23: lfsr_taps = 32'h0042_0000;
      24: lfsr_taps = 32'h00E1_0000;  25: lfsr_taps = 32'h0120_0000;
      26: lfsr_taps = 32'h0200_0023;  27: lfsr_taps = 32'h0400_0013;
      28: lfsr_taps = 32'h0900_0000;  29: lfsr_taps = 32'h1400_0000;
      30: lfsr_taps = 32'h2000_0029;  31: lfsr_taps = 32'h4800_0000;
      32: lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_0003;
    endcase
  endfunction

  localparam logic [31:0]   TAPS_ALL = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];

  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  function automatic logic [DW-1:0] seed_fix(input logic [DW-1:0] s);
    seed_fix = (s == '0) ? DW'(1) : s;
  endfunction

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [DW-1:0] pattern(input pat_e m, input logic [AW-1:0] a,
                                            input logic [DW-1:0] s, input logic [DW-1:0] l);
    int unsigned ai;
    ai = 32'(a);
    case (m)
      PAT_ADD:  pattern = DW'(a) + s;
      PAT_WALK: pattern = DW'(1) << (ai % DW);
      PAT_LFSR: pattern = l;
      default:  pattern = ~DW'(a);
    endcase
  endfunction

  state_e          state_q, state_d;
  pat_e            mode_q, mode_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [DW-1:0]   lfsr_q, lfsr_d;
  logic [DW-1:0]   pat_q, pat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wren_q, wren_d;
  logic [2:0]      drain_q, drain_d;
  logic [15:0]     err_q, err_d;
  logic [AW-1:0]   first_q, first_d;
  logic            pass_q, pass_d;
  logic [HBW-1:0]  hb_q, hb_d;

  // Compare pipeline: expected word and address travel alongside the read.
  logic            pipe_vld_q  [RD_LAT];
  logic            pipe_vld_d  [RD_LAT];
  logic [DW-1:0]   pipe_exp_q  [RD_LAT];
  logic [DW-1:0]   pipe_exp_d  [RD_LAT];
  logic [AW-1:0]   pipe_addr_q [RD_LAT];
  logic [AW-1:0]   pipe_addr_d [RD_LAT];

  logic            push_vld;
  logic            clear_pipe;
  logic            mismatch;
  logic [AW-1:0]   addr_inc;
  logic [DW-1:0]   lfsr_nxt;

  assign addr_inc = addr_q + AW'(1);
  assign lfsr_nxt = lfsr_step(lfsr_q);
  assign mismatch = pipe_vld_q[RD_LAT-1] && (ram.ram_q != pipe_exp_q[RD_LAT-1]);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    pat_d      = pat_q;
    addr_d     = addr_q;
    wren_d     = 1'b0;
    drain_d    = drain_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    hb_d       = hb_q + HBW'(1);
    push_vld   = 1'b0;
    clear_pipe = 1'b0;

    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    first_d = pipe_addr_q[RD_LAT-1];
      pass_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WRITE;
          mode_d     = pat_e'(mode);
          seed_d     = seed;
          lfsr_d     = seed_fix(seed);
          addr_d     = '0;
          wren_d     = 1'b1;
          pat_d      = pattern(pat_e'(mode), '0, seed, seed_fix(seed));
          err_d      = '0;
          first_d    = '0;
          pass_d     = 1'b1;
          clear_pipe = 1'b1;
        end
      end
      S_WRITE: begin
        if (addr_q == '1) begin
          // Replay the LFSR from its seed so read-back expects the same words.
          state_d = S_READ;
          addr_d  = '0;
          lfsr_d  = seed_fix(seed_q);
          pat_d   = pattern(mode_q, '0, seed_q, seed_fix(seed_q));
        end else begin
          addr_d = addr_inc;
          wren_d = 1'b1;
          lfsr_d = lfsr_nxt;
          pat_d  = pattern(mode_q, addr_inc, seed_q, lfsr_nxt);
        end
      end
      S_READ: begin
        push_vld = 1'b1;
        if (addr_q == '1) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_inc;
          lfsr_d = lfsr_nxt;
          pat_d  = pattern(mode_q, addr_inc, seed_q, lfsr_nxt);
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(RD_LAT - 1)) state_d = S_DONE;
        else                            drain_d = drain_q + 3'd1;
      end
      S_DONE: begin
`ifdef RAM_BIST_LOOP_EN
        // Held start reruns with the latched mode/seed; results accumulate.
        if (start) begin
          state_d    = S_WRITE;
          lfsr_d     = seed_fix(seed_q);
          addr_d     = '0;
          wren_d     = 1'b1;
          pat_d      = pattern(mode_q, '0, seed_q, seed_fix(seed_q));
          clear_pipe = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    pipe_vld_d[0]  = push_vld;
    pipe_exp_d[0]  = pat_q;
    pipe_addr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    if (clear_pipe) begin
      for (int i = 0; i < RD_LAT; i++) pipe_vld_d[i] = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= PAT_ADD;
      seed_q  <= '0;
      lfsr_q  <= '0;
      pat_q   <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      drain_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b1;
      hb_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_vld_q[i] <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      hb_q    <= hb_d;
      for (int i = 0; i < RD_LAT; i++) pipe_vld_q[i] <= pipe_vld_d[i];
    end
  end

  // NOTE: pipeline payload is not reset; it is only consumed when the reset
  // valid flag beside it is set, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_exp_q[i]  <= pipe_exp_d[i];
      pipe_addr_q[i] <= pipe_addr_d[i];
    end
  end

  assign ram.ram_addr   = addr_q;
  assign ram.ram_wren   = wren_q;
  assign ram.ram_data   = wren_q ? pat_q : '0;
  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = first_q;
  assign led            = {~pass_q, hb_q[HB_BIT]};

endmodule

// File: tb/tb_ram_bist_seq.sv
// -----------------------------------------------------------------------------
// tb_ram_bist_seq
// Self-checking bench for ram_bist_seq (DW=8, AW=4, RD_LAT=2, HB_BIT=4).
// A RAM model with fault injection sits on the bus; expected write traffic is
// queued per run and checked word by word, and each scenario task checks the
// run results (done timing, pass, err_cnt, first_err_addr, led).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_bist_seq;
  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int RD_LAT  = 2;
  localparam int HB_BIT  = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int RUN_LEN = 2 * DEPTH + RD_LAT + 1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic          clk, rst, start;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [1:0]    led;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t sb_q[$];
  wr_t mon_e;

  // Fault injection on read: OR mask at one address, AND-clear mask everywhere.
  logic [AW-1:0] f_addr    = '0;
  logic [DW-1:0] f_or_mask = '0;
  logic [DW-1:0] f_clr     = '0;

  ram_bist_seq_if #(.DW(DW), .AW(AW)) bus ();

  ram_bist_seq #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .HB_BIT(HB_BIT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .ram(bus),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears RD_LAT cycles after the address.
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] rd_p [RD_LAT];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
    rd_p[0] <= (mem[bus.ram_addr] | ((bus.ram_addr == f_addr) ? f_or_mask : '0)) & ~f_clr;
    for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
  end
  assign bus.ram_q = rd_p[RD_LAT-1];

  // Write scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.ram_wren) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_sb: unexpected write addr=%0d data=%h", bus.ram_addr, bus.ram_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.ram_addr !== mon_e.addr || bus.ram_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL write_sb: got addr=%0d data=%h want addr=%0d data=%h",
                   bus.ram_addr, bus.ram_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] l);
    return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
  endfunction

  task automatic push_expected(input logic [1:0] m, input logic [DW-1:0] s);
    logic [DW-1:0] l;
    wr_t e;
    l = (s == 8'h00) ? 8'h01 : s;
    for (int a = 0; a < DEPTH; a++) begin
      e.addr = AW'(a);
      case (m)
        2'd0:    e.data = DW'(a) + s;
        2'd1:    e.data = 8'h01 << (a % DW);
        2'd2:    e.data = l;
        default: e.data = ~DW'(a);
      endcase
      sb_q.push_back(e);
      l = lfsr_next(l);
    end
  endtask

  task automatic do_run(input logic [1:0] m, input logic [DW-1:0] s,
                        output int done_cyc, output int n_done, output logic r_pass,
                        output logic [15:0] r_err, output logic [AW-1:0] r_first,
                        output logic r_led1);
    push_expected(m, s);
    @(negedge clk);
    mode = m; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; n_done = 0;
    r_pass = 1'bx; r_err = 'x; r_first = 'x; r_led1 = 1'bx;
    for (int cyc = 1; cyc <= RUN_LEN + 15; cyc++) begin
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; r_pass = pass; r_err = err_cnt; r_first = first_err_addr; r_led1 = led[1];
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, bus.ram_wren, bus.ram_addr, bus.ram_data, err_cnt, first_err_addr, pass, led}
        !== {1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd0, 4'd0, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b wren=%b addr=%0d data=%h err=%0d first=%0d pass=%b led=%b",
               busy, done, bus.ram_wren, bus.ram_addr, bus.ram_data, err_cnt, first_err_addr, pass, led);
    end
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_tests++;
    if (led[0] !== 1'b0) begin n_fail++; $display("FAIL heartbeat_15: got %b want 0", led[0]); end
    @(posedge clk); #1;
    n_tests++;
    if (led[0] !== 1'b1) begin n_fail++; $display("FAIL heartbeat_16: got %b want 1", led[0]); end
  endtask

  task automatic test_fill_addr_seed();
    int dc, nd; logic p, l1; logic [15:0] e; logic [AW-1:0] f;
    do_run(2'd0, 8'h03, dc, nd, p, e, f, l1);
    n_tests++; if (dc != RUN_LEN) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want %0d", dc, RUN_LEN); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL fill_done_count: got %0d want 1", nd); end
    n_tests++; if (p !== 1'b1 || e !== 16'd0 || l1 !== 1'b0) begin
      n_fail++; $display("FAIL fill_result: pass=%b err=%0d led1=%b want 1 0 0", p, e, l1); end
    n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL fill_writes_left: got %0d want 0", sb_q.size()); end
    n_tests++; if (busy !== 1'b0 || pass !== 1'b1) begin
      n_fail++; $display("FAIL fill_idle_hold: busy=%b pass=%b want 0 1", busy, pass); end
  endtask

  task automatic test_stuck_high();
    int dc, nd; logic p, l1; logic [15:0] e; logic [AW-1:0] f;
    f_addr = 4'd5; f_or_mask = 8'h04;
    do_run(2'd3, 8'h00, dc, nd, p, e, f, l1);
    f_or_mask = '0;
    n_tests++; if (dc != RUN_LEN) begin n_fail++; $display("FAIL stuck1_done_cycle: got %0d want %0d", dc, RUN_LEN); end
    n_tests++; if (e !== 16'd1) begin n_fail++; $display("FAIL stuck1_err_cnt: got %0d want 1", e); end
    n_tests++; if (f !== 4'd5) begin n_fail++; $display("FAIL stuck1_first: got %0d want 5", f); end
    n_tests++; if (p !== 1'b0 || l1 !== 1'b1) begin
      n_fail++; $display("FAIL stuck1_pass_led: pass=%b led1=%b want 0 1", p, l1); end
  endtask

  task automatic test_walking_stuck_low();
    int dc, nd; logic p, l1; logic [15:0] e; logic [AW-1:0] f;
    f_clr = 8'h01;
    do_run(2'd1, 8'h00, dc, nd, p, e, f, l1);
    f_clr = '0;
    n_tests++; if (e !== 16'd2) begin n_fail++; $display("FAIL walk_err_cnt: got %0d want 2", e); end
    n_tests++; if (f !== 4'd0) begin n_fail++; $display("FAIL walk_first: got %0d want 0", f); end
    n_tests++; if (p !== 1'b0) begin n_fail++; $display("FAIL walk_pass: got %b want 0", p); end
    n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL walk_writes_left: got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_lfsr();
    int dc, nd; logic p, l1; logic [15:0] e; logic [AW-1:0] f;
    logic [DW-1:0] seeds [2];
    seeds[0] = 8'h00; seeds[1] = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      do_run(2'd2, seeds[k], dc, nd, p, e, f, l1);
      n_tests++; if (p !== 1'b1 || e !== 16'd0) begin
        n_fail++; $display("FAIL lfsr_seed_%h: pass=%b err=%0d want 1 0", seeds[k], p, e); end
      n_tests++; if (dc != RUN_LEN) begin n_fail++; $display("FAIL lfsr_done_cycle: got %0d want %0d", dc, RUN_LEN); end
    end
  endtask

  task automatic test_mid_run_reset();
    int dc, nd; logic p, l1; logic [15:0] e; logic [AW-1:0] f;
    f_addr = 4'd0; f_or_mask = 8'h80;
    push_expected(2'd0, 8'h03);
    @(negedge clk);
    mode = 2'd0; seed = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1 || err_cnt !== 16'd1 || pass !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pre: busy=%b err=%0d pass=%b want 1 1 0", busy, err_cnt, pass); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, done, bus.ram_wren, bus.ram_addr, bus.ram_data, err_cnt, first_err_addr, pass, led}
        !== {1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'd0, 4'd0, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL midrst_values: busy=%b done=%b wren=%b addr=%0d data=%h err=%0d first=%0d pass=%b led=%b",
               busy, done, bus.ram_wren, bus.ram_addr, bus.ram_data, err_cnt, first_err_addr, pass, led);
    end
    rst = 1'b0;
    f_or_mask = '0;
    sb_q.delete();
    nd = 0;
    for (int c = 0; c < RUN_LEN + 5; c++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      @(posedge clk); #1;
    end
    n_tests++; if (nd != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles want 0", nd); end
    do_run(2'd0, 8'h03, dc, nd, p, e, f, l1);
    n_tests++; if (p !== 1'b1 || e !== 16'd0 || dc != RUN_LEN) begin
      n_fail++; $display("FAIL midrst_rerun: pass=%b err=%0d done_cyc=%0d want 1 0 %0d", p, e, dc, RUN_LEN); end
  endtask

  task automatic test_ignored_start();
    int dc, nd;
    logic drop;
    push_expected(2'd1, 8'h00);
    @(negedge clk);
    mode = 2'd1; seed = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1; nd = 0; drop = 1'b0;
    for (int cyc = 1; cyc <= RUN_LEN + 40; cyc++) begin
      if (drop) begin start = 1'b0; drop = 1'b0; end
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (dc < 0) dc = cyc;
`ifndef RAM_BIST_LOOP_EN
        start = 1'b1; drop = 1'b1;
`endif
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    n_tests++; if (dc != RUN_LEN) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want %0d", dc, RUN_LEN); end
    n_tests++; if (busy !== 1'b0 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL ignore_idle: busy=%b writes_left=%0d want 0 0", busy, sb_q.size()); end
  endtask

`ifdef RAM_BIST_LOOP_EN
  task automatic test_loop();
    int nd;
    int dcyc [3];
    logic [15:0] derr [3];
    logic drop;
    f_addr = 4'd5; f_or_mask = 8'h04;
    for (int k = 0; k < 3; k++) push_expected(2'd3, 8'h00);
    @(negedge clk);
    mode = 2'd3; seed = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    nd = 0; drop = 1'b0;
    for (int k = 0; k < 3; k++) begin dcyc[k] = -1; derr[k] = 'x; end
    for (int cyc = 1; cyc <= 3 * RUN_LEN + 20; cyc++) begin
      if (drop) begin start = 1'b0; drop = 1'b0; end
      if (done === 1'b1) begin
        if (nd < 3) begin dcyc[nd] = cyc; derr[nd] = err_cnt; end
        nd++;
        if (nd == 2) drop = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; f_or_mask = '0;
    n_tests++; if (nd != 3) begin n_fail++; $display("FAIL loop_done_count: got %0d want 3", nd); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dcyc[k] != (k + 1) * RUN_LEN || derr[k] !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL loop_%0d: done_cyc=%0d err=%0d want %0d %0d", k, dcyc[k], derr[k], (k + 1) * RUN_LEN, k + 1);
      end
    end
    n_tests++; if (pass !== 1'b0 || first_err_addr !== 4'd5 || busy !== 1'b0) begin
      n_fail++; $display("FAIL loop_final: pass=%b first=%0d busy=%b want 0 5 0", pass, first_err_addr, busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_addr_seed();
    test_stuck_high();
    test_walking_stuck_low();
    test_lfsr();
    test_mid_run_reset();
    test_ignored_start();
`ifdef RAM_BIST_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
